// File: rtl/div_pkg.sv
// Shared definitions for the 16-bit iterative restoring divider:
// datapath width, iteration count and the three-state controller encoding.
package div_pkg;

    localparam int DIV_W      = 16;
    localparam int ITER_COUNT = 16;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Counter value seen on the final RUN edge; the counter wraps to 0 on that edge.
    function automatic logic [CNT_W-1:0] last_iter();
        return CNT_W'(ITER_COUNT - 1);
    endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Combinational trial subtraction for one restoring step:
// 17-bit partial remainder minus the zero-extended 16-bit divisor.
module div_sub_stage
    import div_pkg::*;
(
    input  logic [DIV_W:0]   minuend,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] difference,
    output logic             non_neg
);

    logic [DIV_W:0] trial;

    assign trial = minuend - {1'b0, divisor};

    // With a set top bit the minuend already exceeds any 16-bit divisor;
    // otherwise both operands fit in 16 bits and bit 16 is the sign of the result.
    assign non_neg = minuend[DIV_W] | ~trial[DIV_W];

    // A non-negative trial is always smaller than the divisor, so 16 bits hold it.
    assign difference = trial[DIV_W-1:0];

endmodule

// File: rtl/iter_divider_16bit.sv
// Unsigned 16-bit restoring divider: one quotient bit per clock over 16 RUN cycles,
// then a single-cycle DONE pulse. A zero divisor short-circuits straight to DONE.
module iter_divider_16bit
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic [DIV_W-1:0] quo_reg;
    logic [DIV_W-1:0] rem_reg;
    logic [DIV_W-1:0] divisor_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dbz_reg;

    // The 17-bit partial remainder is the stored remainder shifted left with the
    // next dividend bit; the stored part stays below the divisor so 16 bits suffice.
    logic [DIV_W:0]   minuend;
    logic [DIV_W-1:0] trial_diff;
    logic             trial_ok;

    assign minuend = {rem_reg, quo_reg[DIV_W-1]};

    div_sub_stage u_sub (
        .minuend    (minuend),
        .divisor    (divisor_reg),
        .difference (trial_diff),
        .non_neg    (trial_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            dbz_reg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    if (start) begin
                        busy_reg <= 1'b1;
                        if (divisor == '0) begin
                            quo_reg  <= {DIV_W{1'b1}};
                            rem_reg  <= dividend;
                            dbz_reg  <= 1'b1;
                            done_reg <= 1'b1;
                            state    <= DONE;
                        end else begin
                            quo_reg     <= dividend;
                            rem_reg     <= '0;
                            divisor_reg <= divisor;
                            count       <= '0;
                            dbz_reg     <= 1'b0;
                            state       <= RUN;
                        end
                    end
                end

                RUN: begin
                    quo_reg <= {quo_reg[DIV_W-2:0], trial_ok};
                    rem_reg <= trial_ok ? trial_diff : minuend[DIV_W-1:0];
                    count   <= count + 1'b1;
                    if (count == last_iter()) begin
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quo_reg;
    assign remainder   = rem_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_iter_divider_16bit.sv
// Directed and randomized checks of iter_divider_16bit: latency, results,
// divide-by-zero, ignored starts, and reset in the middle of an operation.
module tb_iter_divider_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    iter_divider_16bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done after the accepting edge and checks the latency.
    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] exp_q;
        logic [15:0] exp_r;
        exp_q = (b == 16'd0) ? 16'hFFFF : a / b;
        exp_r = (b == 16'd0) ? a : a % b;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        wait_done(tag, (b == 16'd0) ? 0 : 16);
        check({tag, "_q"},   quotient, exp_q);
        check({tag, "_r"},   remainder, exp_r);
        check({tag, "_dbz"}, div_by_zero, (b == 16'd0));
        tick();
        check({tag, "_done_fall"}, done, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_q",    quotient, 16'd0);
        check("rst_r",    remainder, 16'd0);
        check("rst_dbz",  div_by_zero, 1'b0);
        rst_n = 1'b1;
        tick();

        // 100 / 7 with exact cycle accounting
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("d100_busy", busy, 1'b1);
        check("d100_done0", done, 1'b0);
        repeat (15) tick();
        check("d100_early", done, 1'b0);
        tick();
        check("d100_done", done, 1'b1);
        check("d100_q", quotient, 16'd14);
        check("d100_r", remainder, 16'd2);
        check("d100_dbz", div_by_zero, 1'b0);
        check("d100_busy_done", busy, 1'b1);

        // start in the DONE cycle is ignored, the next IDLE cycle accepts it
        start    = 1'b1;
        dividend = 16'd3;
        divisor  = 16'd10;
        tick();
        check("done_start_ign", busy, 1'b0);
        check("hold_q", quotient, 16'd14);
        check("hold_r", remainder, 16'd2);
        tick();
        start = 1'b0;
        check("b2b_busy", busy, 1'b1);
        wait_done("d3", 16);
        check("d3_q", quotient, 16'd0);
        check("d3_r", remainder, 16'd3);
        tick();

        do_op("ffff_1",    16'hFFFF, 16'd1);
        do_op("div0",      16'd5,    16'd0);
        do_op("zero_num",  16'd0,    16'd5);
        do_op("ffff_ffff", 16'hFFFF, 16'hFFFF);
        do_op("ffff_0",    16'hFFFF, 16'd0);
        do_op("zero_zero", 16'd0,    16'd0);
        do_op("ffff_fffe", 16'hFFFF, 16'hFFFE);
        do_op("big_small", 16'h8000, 16'd3);

        // start while busy is ignored
        dividend = 16'd1000;
        divisor  = 16'd9;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_busy", busy, 1'b1);
        repeat (10) tick();
        check("busy_start_early", done, 1'b0);
        tick();
        check("busy_start_done", done, 1'b1);
        check("busy_start_q", quotient, 16'd111);
        check("busy_start_r", remainder, 16'd1);
        tick();

        // reset in the middle of RUN
        dividend = 16'd1000;
        divisor  = 16'd9;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_q",    quotient, 16'd0);
        check("midrst_r",    remainder, 16'd0);
        check("midrst_dbz",  div_by_zero, 1'b0);
        repeat (12) tick();
        check("midrst_no_done", done, 1'b0);
        rst_n = 1'b1;
        tick();
        check("midrst_idle", busy, 1'b0);
        do_op("after_rst", 16'd49, 16'd7);

        // randomized operands against the reference model
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case (i % 10)
                0: rb = 16'd0;
                1: ra = 16'hFFFF;
                2: rb = 16'hFFFF;
                3: ra = 16'd0;
                4: rb = 16'($urandom_range(1, 15));
                default: ;
            endcase
            do_op("rand", ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
